// File: rtl/alu_result_fifo.sv
// First-word-fall-through queue of ALU results and flags, with a sticky
// overflow indicator that remembers any accepted overflow until cleared.
module alu_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_y,
  input  logic                       in_cout,
  input  logic                       in_neg,
  input  logic                       in_zero,
  input  logic                       in_ovf,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_y,
  output logic [3:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       sticky_ovf,
  input  logic                       sticky_clr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = WIDTH + 4;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  // Handshake decode uses registered occupancy only, so a pop never frees a slot in the same cycle.
  always_comb begin
    in_ready  = (count_q < CW'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    head      = mem[rd_ptr];
    out_y     = '0;
    out_flags = '0;
    if (out_valid) begin
      out_y     = head[EW-1:4];
      out_flags = head[3:0];
    end
  end

  assign count = count_q;

  // Storage is not reset; the out_valid gate keeps stale entries off the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_y, in_cout, in_neg, in_zero, in_ovf};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      sticky_ovf <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // An overflow push on the same edge as a clear wins.
      if (push && in_ovf) begin
        sticky_ovf <= 1'b1;
      end else if (sticky_clr) begin
        sticky_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: vector table plus hand sequences for
// wrap-around and asynchronous reset.
module tb_alu_result_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_y;
  logic             in_cout;
  logic             in_neg;
  logic             in_zero;
  logic             in_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [3:0]       out_flags;
  logic [2:0]       count;
  logic             sticky_ovf;
  logic             sticky_clr;

  int total;
  int bad;

  alu_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
    .in_cout(in_cout), .in_neg(in_neg), .in_zero(in_zero), .in_ovf(in_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_flags(out_flags), .count(count),
    .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] y;
    logic [3:0]  fl;
    logic        ordy;
    logic        clr;
    logic [2:0]  e_cnt;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_y;
    logic [3:0]  e_fl;
    logic        e_st;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] y, input logic [3:0] fl,
                       input logic ordy, input logic clr);
    in_valid   = iv;
    in_y       = y;
    {in_cout, in_neg, in_zero, in_ovf} = fl;
    out_ready  = ordy;
    sticky_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

    vecs[0]  = '{1'b1, 32'h5,        4'h0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h5,        4'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 32'h0,        4'h0, 1'b0};
    vecs[2]  = '{1'b1, 32'h11,       4'h8, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h11,       4'h8, 1'b0};
    vecs[3]  = '{1'b1, 32'h22,       4'h4, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 32'h11,       4'h8, 1'b0};
    vecs[4]  = '{1'b1, 32'h33,       4'h2, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 32'h11,       4'h8, 1'b0};
    vecs[5]  = '{1'b1, 32'h44,       4'h0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 32'h11,       4'h8, 1'b0};
    vecs[6]  = '{1'b1, 32'h55,       4'h1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 32'h11,       4'h8, 1'b0};
    vecs[7]  = '{1'b1, 32'h55,       4'h0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 32'h22,       4'h4, 1'b0};
    vecs[8]  = '{1'b1, 32'h55,       4'h0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 32'h22,       4'h4, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 32'h33,       4'h2, 1'b0};
    vecs[10] = '{1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 32'h44,       4'h0, 1'b0};
    vecs[11] = '{1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 32'h55,       4'h0, 1'b0};
    vecs[12] = '{1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 32'h0,        4'h0, 1'b0};
    vecs[13] = '{1'b1, 32'h80000000, 4'h1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h80000000, 4'h1, 1'b1};
    vecs[14] = '{1'b1, 32'h7,        4'h1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 32'h80000000, 4'h1, 1'b1};
    vecs[15] = '{1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 32'h7,        4'h1, 1'b0};
    vecs[16] = '{1'b1, 32'h9,        4'h0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 32'h9,        4'h0, 1'b0};
    vecs[17] = '{1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 32'h0,        4'h0, 1'b0};
    vecs[18] = '{1'b0, 32'h0,        4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 32'h0,        4'h0, 1'b0};

    // Reset state, with push/pop attempts that must be ignored
    drive(1'b1, 32'hDEAD, 4'hF, 1'b1, 1'b0);
    tick();
    tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_y", 64'(out_y), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_sticky", 64'(sticky_ovf), 64'd0);
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].y, vecs[i].fl, vecs[i].ordy, vecs[i].clr);
      tick();
      check($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
      check($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
      check($sformatf("v%0d_out_y", i), 64'(out_y), 64'(vecs[i].e_y));
      check($sformatf("v%0d_out_flags", i), 64'(out_flags), 64'(vecs[i].e_fl));
      check($sformatf("v%0d_sticky", i), 64'(sticky_ovf), 64'(vecs[i].e_st));
    end

    // Streaming 1..10 with continuous pop: head tracks the newest push, occupancy stays at 1
    for (int v = 1; v <= 10; v++) begin
      drive(1'b1, 32'(v), 4'h0, 1'b1, 1'b0);
      tick();
      check($sformatf("wrap%0d_out_y", v), 64'(out_y), 64'(v));
      check($sformatf("wrap%0d_count", v), 64'(count), 64'd1);
    end
    drive(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    tick();
    check("wrap_drain_count", 64'(count), 64'd0);
    check("wrap_drain_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset with three entries queued and sticky set
    drive(1'b1, 32'hA1, 4'h1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hA2, 4'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hA3, 4'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    check("pre_rst_count", 64'(count), 64'd3);
    check("pre_rst_sticky", 64'(sticky_ovf), 64'd1);
    check("pre_rst_out_y", 64'(out_y), 64'hA1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_sticky", 64'(sticky_ovf), 64'd0);
    check("arst_out_y", 64'(out_y), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("post_rst_count", 64'(count), 64'd0);
    drive(1'b1, 32'hAB, 4'h2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    check("post_rst_out_y", 64'(out_y), 64'hAB);
    check("post_rst_flags", 64'(out_flags), 64'h2);
    check("post_rst_count1", 64'(count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
